// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: per-frame Avalon-MM read master that streams frame-buffer words into the VGA pixel FIFO
module vga_fb_fetch #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 24,
  parameter int USEDW_W     = 12,
  parameter int FILL_THRESH = 4000,
  parameter int ADDR_STEP   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               frame_start,
  input  logic [ADDR_W-1:0]  fb_base,
  input  logic [CNT_W-1:0]   frame_words,
  output logic [ADDR_W-1:0]  avm_read_address,
  output logic               avm_read_read,
  input  logic [DATA_W-1:0]  avm_read_readdata,
  input  logic               avm_read_waitrequest,
  output logic               fifo_write_write,
  output logic [DATA_W-1:0]  fifo_write_writedata,
  input  logic               fifo_write_waitrequest,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  output logic               busy,
  output logic               frame_done
);
  typedef enum logic [2:0] {IDLE, WAIT_ROOM, READ, PUSH, DONE} state_t;
  localparam logic [31:0] THRESH = 32'(FILL_THRESH);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic room;
  assign room = 32'(fifo_wrusedw) < THRESH;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (frame_start && enable) begin
        addr_d  = fb_base;
        count_d = frame_words;
        state_d = frame_words == '0 ? DONE : WAIT_ROOM;
      end
      WAIT_ROOM: state_d = !enable ? IDLE : room ? READ : WAIT_ROOM;
      READ: if (!avm_read_waitrequest) begin
        hold_d  = avm_read_readdata;
        addr_d  = addr_q + ADDR_W'(ADDR_STEP);
        count_d = count_q - 1'b1;
        state_d = PUSH;
      end
      PUSH: if (!fifo_write_waitrequest)
        state_d = count_q == '0 ? DONE : !enable ? IDLE : room ? READ : WAIT_ROOM;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end
  assign avm_read_read        = state_q == READ;
  assign avm_read_address     = avm_read_read ? addr_q : '0;
  assign fifo_write_write     = state_q == PUSH && !fifo_write_waitrequest;
  assign fifo_write_writedata = state_q == PUSH ? hold_q : '0;
  assign busy                 = state_q != IDLE;
  assign frame_done           = state_q == DONE;
endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb_vga_fb_fetch: randomized scoreboard bench for vga_fb_fetch against a frame-level memory model
module tb_vga_fb_fetch;
  logic clk = 0, reset_n = 0, enable = 0, frame_start = 0;
  logic [31:0] fb_base = 0;
  logic [23:0] frame_words = 0;
  logic [31:0] avm_read_address;
  logic avm_read_read, avm_read_waitrequest = 0;
  logic [15:0] avm_read_readdata, fifo_write_writedata;
  logic fifo_write_write, fifo_write_waitrequest = 0;
  logic [11:0] fifo_wrusedw = 0, used_at_edge = 0;
  logic busy, frame_done;
  int checks = 0, errors = 0;
  vga_fb_fetch dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
    .fb_base(fb_base), .frame_words(frame_words),
    .avm_read_address(avm_read_address), .avm_read_read(avm_read_read),
    .avm_read_readdata(avm_read_readdata), .avm_read_waitrequest(avm_read_waitrequest),
    .fifo_write_write(fifo_write_write), .fifo_write_writedata(fifo_write_writedata),
    .fifo_write_waitrequest(fifo_write_waitrequest), .fifo_wrusedw(fifo_wrusedw),
    .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mem_word(logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h5a3c;
  endfunction
  assign avm_read_readdata = mem_word(avm_read_address);
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  bit aw_rand = 0, fw_rand = 0, used_rand = 0;
  int rd_idx = 0, stall_idx = 0, stall_len = 0, stall_left = 0;
  logic rd_prev_env = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (avm_read_read && !rd_prev_env) begin
      rd_idx++;
      stall_left = rd_idx == stall_idx ? stall_len : 0;
    end
    rd_prev_env = avm_read_read;
    if (stall_left > 0) begin
      avm_read_waitrequest = 1;
      stall_left--;
    end else avm_read_waitrequest = aw_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (fw_rand) fifo_write_waitrequest = $urandom_range(0, 3) == 0;
    if (used_rand) fifo_wrusedw = 12'($urandom_range(3990, 4005));
  end
  logic [31:0] exp_addr[$];
  logic [15:0] exp_data[$];
  int rd_lens[$];
  int rd_rises = 0, done_cnt = 0, writes = 0, rd_len = 0;
  logic p_rd = 0, p_aw = 0, p_done = 0, done_due = 0;
  logic [31:0] p_addr = 0;
  always @(posedge clk) used_at_edge <= fifo_wrusedw;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      p_rd = 0;
      p_done = 0;
      done_due = 0;
      rd_len = 0;
    end else begin
      if (done_due) check("done_after_last_push", frame_done, 1);
      done_due = 0;
      if (p_rd && p_aw) begin
        check("read_held", avm_read_read, 1);
        check("addr_held", avm_read_address, p_addr);
      end
      if (avm_read_read && !p_rd) begin
        rd_rises++;
        rd_len = 0;
        check("read_needs_room", used_at_edge < 12'd4000, 1);
      end
      if (avm_read_read) begin
        rd_len++;
        check("busy_in_read", busy, 1);
        if (!avm_read_waitrequest) begin
          rd_lens.push_back(rd_len);
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got addr %0h expected none", avm_read_address);
          end else check("read_addr", avm_read_address, exp_addr.pop_front());
        end
      end
      if (fifo_write_write) begin
        writes++;
        check("write_not_full", fifo_write_waitrequest, 0);
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got data %0h expected none", fifo_write_writedata);
        end else begin
          check("write_data", fifo_write_writedata, exp_data.pop_front());
          done_due = exp_data.size() == 0;
        end
      end
      if (frame_done) begin
        done_cnt++;
        check("done_queue_empty", exp_data.size(), 0);
        check("done_single_cycle", p_done, 0);
      end
      p_rd = avm_read_read;
      p_aw = avm_read_waitrequest;
      p_addr = avm_read_address;
      p_done = frame_done;
    end
  end
  task automatic start_frame(logic [31:0] base, int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(base + 32'(2 * i));
      exp_data.push_back(mem_word(base + 32'(2 * i)));
    end
    rd_idx = 0;
    fb_base = base;
    frame_words = 24'(n);
    frame_start = 1;
    enable = 1;
    @(negedge clk);
    frame_start = 0;
    fb_base = $urandom;
    frame_words = 24'($urandom);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("frame_finishes", busy, 0);
  endtask
  task automatic run_frame(logic [31:0] base, int n);
    int d0 = done_cnt, w0 = writes;
    start_frame(base, n);
    wait_idle();
    check("frame_done_count", done_cnt - d0, 1);
    check("frame_write_count", writes - w0, n);
    check("frame_reads_left", exp_addr.size(), 0);
  endtask
  task automatic check_outputs_zero(string name);
    check(name, {avm_read_address, avm_read_read, fifo_write_write, fifo_write_writedata, busy, frame_done}, 0);
  endtask
  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int d0, w0, r0, l0, k;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    reset_n = 1;
    run_frame(32'h0010_0000, 4);
    stall_idx = 2;
    stall_len = 3;
    l0 = rd_lens.size();
    run_frame(32'h0010_0000, 4);
    check("stall_read_cycles", rd_lens[l0 + 1], 4);
    stall_idx = 0;
    fifo_wrusedw = 4000;
    d0 = done_cnt;
    start_frame(32'h0030_0000, 2);
    repeat (6) @(negedge clk);
    check("throttle_no_read", avm_read_read, 0);
    check("throttle_busy", busy, 1);
    fifo_wrusedw = 3999;
    @(negedge clk);
    check("read_after_room", avm_read_read, 1);
    fifo_wrusedw = 0;
    wait_idle();
    check("throttle_done", done_cnt - d0, 1);
    fifo_write_waitrequest = 1;
    w0 = writes;
    start_frame(32'h0040_0000, 3);
    k = 0;
    while (!(avm_read_read && !avm_read_waitrequest) && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_no_write", fifo_write_write, 0);
      check("full_data_held", fifo_write_writedata, mem_word(32'h0040_0000));
    end
    @(posedge clk);
    #1 fifo_write_waitrequest = 0;
    @(negedge clk);
    check("write_after_full", fifo_write_write, 1);
    wait_idle();
    check("full_write_count", writes - w0, 3);
    stall_idx = 2;
    stall_len = 6;
    d0 = done_cnt;
    w0 = writes;
    r0 = rd_rises;
    start_frame(32'h0050_0000, 5);
    k = 0;
    while (rd_rises < r0 + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("abort_in_stalled_read", avm_read_read && avm_read_waitrequest, 1);
    enable = 0;
    wait_idle();
    stall_idx = 0;
    check("abort_writes", writes - w0, 2);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_left_words", exp_data.size(), 3);
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    check("start_ignored_disabled", busy, 0);
    run_frame(32'h0200_0000, 3);
    r0 = rd_rises;
    run_frame(32'h0070_0000, 0);
    check("zero_words_no_read", rd_rises - r0, 0);
    run_frame(32'hffff_fffc, 4);
    aw_rand = 1;
    d0 = done_cnt;
    start_frame(32'h0060_0000, 8);
    repeat (9) @(negedge clk);
    #2 reset_n = 0;
    #1 check_outputs_zero("async_reset_outputs");
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    check("after_reset_idle", {busy, avm_read_read}, 0);
    check("reset_no_done", done_cnt - d0, 0);
    fw_rand = 1;
    used_rand = 1;
    for (int f = 0; f < 12; f++) run_frame({$urandom_range(0, 32'h7fff_ffff), 1'b0}, $urandom_range(1, 24));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
